// File: rtl/cobra_pkg.sv
// Shared types and constants for the snake game control path.
// Holds the judge FSM states, the round outcome encoding and the
// outcome decision helper used by round_outcome_judge.
package cobra_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRACE,
        ARMED,
        DECIDED
    } judge_state_e;

    typedef enum logic [1:0] {
        OUT_NONE,
        OUT_P1,
        OUT_P2,
        OUT_TIE
    } outcome_e;

    // Video frames per second; the default round timeout is one minute.
    localparam int FRAME_RATE = 60;

    // Head-on collisions and double crashes are draws; a lone crash hands
    // the round to the other snake.
    function automatic outcome_e judge_outcome(input logic s1, input logic s2, input logic hh);
        if (hh || (s1 && s2)) begin
            return OUT_TIE;
        end else if (s2) begin
            return OUT_P1;
        end else if (s1) begin
            return OUT_P2;
        end else begin
            return OUT_NONE;
        end
    endfunction

endpackage

// File: rtl/round_outcome_judge_if.sv
// Bus between the snake engines / game-control FSM and the round judge.
// Events on this bus are single-cycle pulses sampled on the rising clock
// edge with no valid/ready handshake: frame_tick, score_clr and the hit
// flags are accepted in the cycle they are high, play_active is a level,
// and the outcome outputs are levels held until play_active drops.
interface round_outcome_judge_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               play_active;
    logic               score_clr;
    logic               s1_hit;
    logic               s2_hit;
    logic               heads_hit;
    logic               player1wins;
    logic               player2wins;
    logic               tie;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;

    modport master (
        output frame_tick, play_active, score_clr, s1_hit, s2_hit, heads_hit,
        input  player1wins, player2wins, tie, p1_score, p2_score
    );

    modport slave (
        input  frame_tick, play_active, score_clr, s1_hit, s2_hit, heads_hit,
        output player1wins, player2wins, tie, p1_score, p2_score
    );
endinterface

// File: rtl/sat_score_counter.sv
// Saturating match score counter, one per player.
// Clear has priority over increment so a menu reset never loses to a win.
module sat_score_counter #(
    parameter int SCORE_W   = 4,
    parameter int MAX_SCORE = 9
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] count
);

    // Count wins up to MAX_SCORE, then hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != SCORE_W'(MAX_SCORE))) begin
            count <= count + SCORE_W'(1);
        end
    end

endmodule

// File: rtl/round_outcome_judge.sv
// Round outcome judge: watches collision flags during play, decides the
// round once per video frame and keeps per-player match scores.
// Optional feature macro: ROUND_TIMEOUT_EN -- when defined, a round with
// no hits for TIMEOUT_FRAMES armed frames is declared a tie.
module round_outcome_judge
    import cobra_pkg::*;
#(
    parameter int GRACE_FRAMES   = 3,
    parameter int MAX_SCORE      = 9,
    parameter int SCORE_W        = 4
`ifdef ROUND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_FRAMES = 60 * FRAME_RATE
`endif
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    round_outcome_judge_if.slave bus,
    output judge_state_e         state_dbg
);

    localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES + 1) : 1;
`ifdef ROUND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
`endif

    judge_state_e       state_q, state_d;
    outcome_e           outcome_q, outcome_d;
    outcome_e           verdict;
    logic [GW-1:0]      grace_q, grace_d;
    logic               s1_l, s2_l, hh_l;
    logic               s1_d, s2_d, hh_d;
    logic               play_q;
    logic               play_rise;
    logic               inc_p1, inc_p2;
    logic [SCORE_W-1:0] p1_cnt, p2_cnt;
`ifdef ROUND_TIMEOUT_EN
    logic [TW-1:0]      frame_q, frame_d;
`endif

    assign play_rise = bus.play_active && !play_q;

    // State, grace counter, hit latches and the held outcome.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            outcome_q <= OUT_NONE;
            grace_q   <= '0;
            s1_l      <= 1'b0;
            s2_l      <= 1'b0;
            hh_l      <= 1'b0;
            play_q    <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            frame_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            outcome_q <= outcome_d;
            grace_q   <= grace_d;
            s1_l      <= s1_d;
            s2_l      <= s2_d;
            hh_l      <= hh_d;
            play_q    <= bus.play_active;
`ifdef ROUND_TIMEOUT_EN
            frame_q   <= frame_d;
`endif
        end
    end

    // Next state, latch updates and per-frame evaluation. Latches only
    // accumulate in ARMED between ticks; a hit on the tick cycle itself is
    // folded straight into that tick's verdict.
    always_comb begin
        state_d   = state_q;
        outcome_d = outcome_q;
        grace_d   = grace_q;
        s1_d      = 1'b0;
        s2_d      = 1'b0;
        hh_d      = 1'b0;
        inc_p1    = 1'b0;
        inc_p2    = 1'b0;
        verdict   = OUT_NONE;
`ifdef ROUND_TIMEOUT_EN
        frame_d   = frame_q;
`endif
        case (state_q)
            IDLE: begin
                outcome_d = OUT_NONE;
                if (play_rise) begin
                    grace_d = GW'(GRACE_FRAMES);
                    if (GRACE_FRAMES == 0) begin
                        state_d = ARMED;
`ifdef ROUND_TIMEOUT_EN
                        frame_d = '0;
`endif
                    end else begin
                        state_d = GRACE;
                    end
                end
            end
            GRACE: begin
                if (!bus.play_active) begin
                    state_d = IDLE;
                end else if (bus.frame_tick) begin
                    if (grace_q <= GW'(1)) begin
                        grace_d = '0;
                        state_d = ARMED;
`ifdef ROUND_TIMEOUT_EN
                        frame_d = '0;
`endif
                    end else begin
                        grace_d = grace_q - GW'(1);
                    end
                end
            end
            ARMED: begin
                if (!bus.play_active) begin
                    state_d = IDLE;
                end else if (bus.frame_tick) begin
                    verdict = judge_outcome(s1_l || bus.s1_hit,
                                            s2_l || bus.s2_hit,
                                            hh_l || bus.heads_hit);
`ifdef ROUND_TIMEOUT_EN
                    // A real hit on the final frame outranks the timeout draw.
                    if ((verdict == OUT_NONE) && (frame_q == TW'(TIMEOUT_FRAMES - 1))) begin
                        verdict = OUT_TIE;
                    end
                    frame_d = frame_q + TW'(1);
`endif
                    if (verdict != OUT_NONE) begin
                        state_d   = DECIDED;
                        outcome_d = verdict;
                        inc_p1    = (verdict == OUT_P1);
                        inc_p2    = (verdict == OUT_P2);
                    end
                end else begin
                    s1_d = s1_l || bus.s1_hit;
                    s2_d = s2_l || bus.s2_hit;
                    hh_d = hh_l || bus.heads_hit;
                end
            end
            DECIDED: begin
                if (!bus.play_active) begin
                    state_d   = IDLE;
                    outcome_d = OUT_NONE;
                end
            end
            default: begin
                state_d   = IDLE;
                outcome_d = OUT_NONE;
            end
        endcase
    end

    sat_score_counter #(
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_p1_score (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc     (inc_p1),
        .clr     (bus.score_clr),
        .count   (p1_cnt)
    );

    sat_score_counter #(
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_p2_score (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .inc     (inc_p2),
        .clr     (bus.score_clr),
        .count   (p2_cnt)
    );

    // The outcome register is non-NONE only in DECIDED, so the decode is
    // one-hot by construction.
    assign bus.player1wins = (outcome_q == OUT_P1);
    assign bus.player2wins = (outcome_q == OUT_P2);
    assign bus.tie         = (outcome_q == OUT_TIE);
    assign bus.p1_score    = p1_cnt;
    assign bus.p2_score    = p2_cnt;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_round_outcome_judge.sv
// Bench for round_outcome_judge: table of single-frame rounds plus
// hand-written grace, reset, saturation/clear and (with ROUND_TIMEOUT_EN)
// timeout sequences. Outcome events are checked against a queue of
// expected {due cycle, outcome, scores} words.
module tb_round_outcome_judge;
    import cobra_pkg::*;

    localparam int SCORE_W      = 4;
    localparam int MAX_SCORE    = 9;
    localparam int GRACE_FRAMES = 3;
`ifdef ROUND_TIMEOUT_EN
    localparam int TIMEOUT_FRAMES = 5;
`endif
    localparam int EW = 16 + 3 + 2 * SCORE_W;

    // ---------------- clock / reset ----------------
    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [15:0]  cyc = '0;
    judge_state_e state_dbg;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 16'd1;

    round_outcome_judge_if #(.SCORE_W(SCORE_W)) bus ();

    round_outcome_judge #(
        .GRACE_FRAMES (GRACE_FRAMES),
        .MAX_SCORE    (MAX_SCORE),
        .SCORE_W      (SCORE_W)
`ifdef ROUND_TIMEOUT_EN
        ,
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
`endif
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_p1 = 0;
    int m_p2 = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2:0] out_bits(input logic [1:0] o);
        case (o)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // o: 1 = player1wins, 2 = player2wins, 3 = tie. Called in the cycle the
    // deciding tick is driven; the outcome is due one cycle later.
    task automatic expect_outcome(input logic [1:0] o, input logic clr);
        if (clr) begin
            m_p1 = 0;
            m_p2 = 0;
        end else if (o == 2'd1 && m_p1 < MAX_SCORE) begin
            m_p1++;
        end else if (o == 2'd2 && m_p2 < MAX_SCORE) begin
            m_p2++;
        end
        exp_q.push_back({cyc + 16'd1, out_bits(o), SCORE_W'(m_p1), SCORE_W'(m_p2)});
    endtask

    logic [2:0] prev_out = 3'b000;

    // Monitor: outcome levels must be one-hot-or-zero every cycle, and each
    // new outcome must match the head of the expected queue.
    always @(negedge Clk) begin
        logic [2:0]    cur;
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        cur = {bus.player1wins, bus.player2wins, bus.tie};
        check("onehot", int'($onehot0(cur)), 1);
        if (cur != 3'b000 && cur != prev_out) begin
            act = {cyc, cur, bus.p1_score, bus.p2_score};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_outcome: got out=%b p1=%0d p2=%0d at cycle %0d, expected none",
                         cur, bus.p1_score, bus.p2_score, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL outcome: got cyc=%0d out=%b p1=%0d p2=%0d, expected cyc=%0d out=%b p1=%0d p2=%0d",
                             act[EW-1 -: 16], act[2*SCORE_W +: 3], act[SCORE_W +: SCORE_W], act[SCORE_W-1:0],
                             exp[EW-1 -: 16], exp[2*SCORE_W +: 3], exp[SCORE_W +: SCORE_W], exp[SCORE_W-1:0]);
                end
            end
        end
        prev_out = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic tick, input logic s1, input logic s2, input logic hh, input logic clr);
        @(negedge Clk);
        bus.frame_tick = tick;
        bus.s1_hit     = s1;
        bus.s2_hit     = s2;
        bus.heads_hit  = hh;
        bus.score_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_play(input logic v);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.play_active = v;
    endtask

    // Raise play_active and run through the grace frames into ARMED.
    task automatic start_round();
        set_play(1'b1);
        for (int g = 0; g < GRACE_FRAMES; g++) begin
            idle(2);
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
        check("armed_after_grace", int'(state_dbg), int'(ARMED));
    endtask

    // Drop play_active and confirm the outputs fall the next cycle.
    task automatic end_round();
        set_play(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("release_out", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
        check("release_state", int'(state_dbg), int'(IDLE));
        idle(2);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       s1_mid;
        logic       s2_mid;
        logic       hh_mid;
        logic       s1_tk;
        logic       s2_tk;
        logic       hh_tk;
        logic [1:0] outc;
    } vec_t;

    vec_t vecs[10];

    task automatic run_round(input vec_t v);
        start_round();
        if (v.s1_mid) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        if (v.s2_mid) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        if (v.hh_mid) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(1'b1, v.s1_tk, v.s2_tk, v.hh_tk, 1'b0);
        if (v.outc != 2'd0) expect_outcome(v.outc, 1'b0);
        idle(1);
        if (v.outc != 2'd0) begin
            // Decided: further hits and ticks change nothing.
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            idle(2);
            check("hold_out", int'({bus.player1wins, bus.player2wins, bus.tie}), int'(out_bits(v.outc)));
            check("hold_p1_score", int'(bus.p1_score), m_p1);
            check("hold_p2_score", int'(bus.p2_score), m_p2);
        end else begin
            check("no_hit_out", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
            check("no_hit_state", int'(state_dbg), int'(ARMED));
        end
        end_round();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};

        bus.frame_tick  = 1'b0;
        bus.play_active = 1'b0;
        bus.score_clr   = 1'b0;
        bus.s1_hit      = 1'b0;
        bus.s2_hit      = 1'b0;
        bus.heads_hit   = 1'b0;

        // Reset values
        idle(2);
        check("rst_out", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
        check("rst_p1_score", int'(bus.p1_score), 0);
        check("rst_p2_score", int'(bus.p2_score), 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);

        // Grace: hits on grace ticks are ignored, first armed tick decides
        set_play(1'b1);
        for (int g = 0; g < GRACE_FRAMES; g++) begin
            idle(1);
            if (g < GRACE_FRAMES - 1) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
        check("grace_quiet", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
        check("grace_state", int'(state_dbg), int'(ARMED));
        check("grace_p2_score", int'(bus.p2_score), 0);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_outcome(2'd2, 1'b0);
        idle(1);
        check("grace_win_p2_score", int'(bus.p2_score), 1);
        end_round();

        // Table of single-frame rounds
        foreach (vecs[i]) run_round(vecs[i]);

        // Asynchronous reset in the middle of an armed round
        start_round();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge Clk);
        Reset_n = 1'b0;
        bus.play_active = 1'b0;
        #1;
        check("midrst_out", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
        check("midrst_p1_score", int'(bus.p1_score), 0);
        check("midrst_p2_score", int'(bus.p2_score), 0);
        check("midrst_state", int'(state_dbg), int'(IDLE));
        m_p1 = 0;
        m_p2 = 0;
        idle(2);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(2);
        start_round();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("post_rst_no_outcome", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
        end_round();

        // Saturation at MAX_SCORE, then clear beating a coincident win
        for (int r = 0; r < 10; r++) begin
            start_round();
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            expect_outcome(2'd1, 1'b0);
            idle(1);
            end_round();
        end
        check("sat_p1_score", int'(bus.p1_score), 9);
        start_round();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_outcome(2'd1, 1'b1);
        idle(1);
        check("clr_p1_score", int'(bus.p1_score), 0);
        end_round();

`ifdef ROUND_TIMEOUT_EN
        // Timeout: silent round draws on the last frame, a hit on it wins
        for (int k = 0; k < 2; k++) begin
            start_round();
            for (int f = 0; f < TIMEOUT_FRAMES - 1; f++) begin
                idle(2);
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            idle(1);
            check("pre_timeout_out", int'({bus.player1wins, bus.player2wins, bus.tie}), 0);
            idle(1);
            step(1'b1, 1'b0, (k == 1), 1'b0, 1'b0);
            expect_outcome((k == 1) ? 2'd1 : 2'd3, 1'b0);
            idle(1);
            end_round();
        end
`endif

        // Final report
        idle(3);
        while (exp_q.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_outcome: got nothing, expected out=%b due cycle %0d",
                     e[2*SCORE_W +: 3], e[EW-1 -: 16]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
